// File: rtl/datapath_seq.sv
// Program/stack sequencer for a small datapath: pc update, branches,
// and a descending memory stack for PUSH/POP/CALL/RET.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   op_valid, op, halt    decoded instruction, halt request
//   target, neg, zero     branch/call destination and ALU flags
//   push_data             PUSH operand
//   op_ready              sequencer accepts an op this cycle
//   mem_req, mem_we       data-memory request and write qualifier
//   mem_addr, mem_wdata   request address and write data
//   mem_ack, mem_rdata    memory completion and read data
//   pop_data, pop_valid   POP result and one-cycle strobe
//   pc, sp                program counter, stack pointer
//   halted, fault         halt status, sticky {overflow, underflow}
module datapath_seq #(
    parameter int AW          = 10,
    parameter int DW          = 16,
    parameter int STACK_TOP   = (1 << AW) - 2,
    parameter int STACK_DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  logic [2:0]    op,
    input  logic          halt,
    input  logic [AW-1:0] target,
    input  logic          neg,
    input  logic          zero,
    input  logic [DW-1:0] push_data,
    output logic          op_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] sp,
    output logic          halted,
    output logic [1:0]    fault
);

    typedef enum logic [1:0] {
        READY,
        MEM,
        HALT,
        FAULT
    } state_t;

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JLT  = 3'd2;
    localparam logic [2:0] OP_JEQ  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_POP  = 3'd5;
    localparam logic [2:0] OP_CALL = 3'd6;
    localparam logic [2:0] OP_RET  = 3'd7;

    // Stack grows downward: empty at STACK_TOP, full STACK_DEPTH below it.
    localparam logic [AW-1:0] SP_EMPTY = AW'(STACK_TOP);
    localparam logic [AW-1:0] SP_FULL  = AW'(STACK_TOP - STACK_DEPTH);

    state_t        state;
    logic [2:0]    pendOp;
    logic [AW-1:0] pendTarget;

    logic [AW-1:0] pcPlus1;
    logic [AW-1:0] spPlus1;
    logic [AW-1:0] spMinus1;
    logic [AW-1:0] branchPc;
    logic          atFull;
    logic          atEmpty;
    logic          isWrite;
    logic          isRead;

    assign op_ready = (state == READY);

    assign pcPlus1  = pc + AW'(1);
    assign spPlus1  = sp + AW'(1);
    assign spMinus1 = sp - AW'(1);
    assign atFull   = (sp == SP_FULL);
    assign atEmpty  = (sp == SP_EMPTY);
    assign isWrite  = (op == OP_PUSH) || (op == OP_CALL);
    assign isRead   = (op == OP_POP) || (op == OP_RET);

    // Next pc for the non-memory ops; flags are sampled with the op.
    always_comb begin
        branchPc = pcPlus1;
        unique case (op)
            OP_JMP: branchPc = target;
            OP_JLT: branchPc = neg ? target : pcPlus1;
            OP_JEQ: branchPc = zero ? target : pcPlus1;
            default: branchPc = pcPlus1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= READY;
            pc         <= '0;
            sp         <= SP_EMPTY;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pop_data   <= '0;
            pop_valid  <= 1'b0;
            halted     <= 1'b0;
            fault      <= 2'b00;
            pendOp     <= OP_NEXT;
            pendTarget <= '0;
        end else begin
            pop_valid <= 1'b0;
            unique case (state)
                READY: begin
                    if (op_valid) begin
                        if (halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (isWrite) begin
                            if (atFull) begin
                                fault[1] <= 1'b1;
                                state    <= FAULT;
                            end else begin
                                mem_req    <= 1'b1;
                                mem_we     <= 1'b1;
                                mem_addr   <= sp;
                                // CALL pushes its return address.
                                mem_wdata  <= (op == OP_CALL)
                                              ? DW'(pcPlus1)
                                              : push_data;
                                pendOp     <= op;
                                pendTarget <= target;
                                state      <= MEM;
                            end
                        end else if (isRead) begin
                            if (atEmpty) begin
                                fault[0] <= 1'b1;
                                state    <= FAULT;
                            end else begin
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= spPlus1;
                                pendOp   <= op;
                                state    <= MEM;
                            end
                        end else begin
                            pc <= branchPc;
                        end
                    end
                end

                MEM: begin
                    // Request stays frozen until the memory acknowledges.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= READY;
                        unique case (pendOp)
                            OP_PUSH: begin
                                sp <= spMinus1;
                                pc <= pcPlus1;
                            end
                            OP_CALL: begin
                                sp <= spMinus1;
                                pc <= pendTarget;
                            end
                            OP_POP: begin
                                sp        <= spPlus1;
                                pc        <= pcPlus1;
                                pop_data  <= mem_rdata;
                                pop_valid <= 1'b1;
                            end
                            default: begin
                                sp <= spPlus1;
                                pc <= mem_rdata[AW-1:0];
                            end
                        endcase
                    end
                end

                HALT: begin
                end

                FAULT: begin
                end

                default: state <= READY;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: branching, stack ops, faults,
// halt and mid-access reset, checked with immediate assertions.
module tb_datapath_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic        halt;
    logic [9:0]  target;
    logic        neg;
    logic        zero;
    logic [15:0] push_data;
    logic        op_ready;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic [9:0]  pc;
    logic [9:0]  sp;
    logic        halted;
    logic [1:0]  fault;

    int passCnt = 0;
    int totalCnt = 0;
    int writes;

    datapath_seq dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .halt(halt), .target(target), .neg(neg), .zero(zero),
        .push_data(push_data), .op_ready(op_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .pop_data(pop_data),
        .pop_valid(pop_valid), .pc(pc), .sp(sp),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] o, input logic [9:0] t,
                         input logic n, input logic z,
                         input logic [15:0] d, input logic h);
        op_valid  = 1'b1;
        op        = o;
        target    = t;
        neg       = n;
        zero      = z;
        push_data = d;
        halt      = h;
        step();
        op_valid = 1'b0;
        halt     = 1'b0;
    endtask

    task automatic ackStep(input logic [15:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; halt = 1'b0;
        target = '0; neg = 1'b0; zero = 1'b0; push_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        doReset();

        check("rst_pc", pc, 10'h000);
        check("rst_sp", sp, 10'h3FE);
        check("rst_ready", op_ready, 1'b1);
        check("rst_req", mem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 2'b00);
        check("rst_popv", pop_valid, 1'b0);

        issue(3'd0, 10'h0, 0, 0, 16'h0, 0);
        check("next1", pc, 10'h001);
        issue(3'd0, 10'h0, 0, 0, 16'h0, 0);
        check("next2", pc, 10'h002);
        issue(3'd0, 10'h0, 0, 0, 16'h0, 0);
        check("next3", pc, 10'h003);
        issue(3'd3, 10'h040, 0, 1, 16'h0, 0);
        check("jeq_taken", pc, 10'h040);
        issue(3'd2, 10'h123, 0, 0, 16'h0, 0);
        check("jlt_fall", pc, 10'h041);
        issue(3'd3, 10'h155, 0, 0, 16'h0, 0);
        check("jeq_fall", pc, 10'h042);
        issue(3'd2, 10'h3FF, 1, 0, 16'h0, 0);
        check("jlt_taken", pc, 10'h3FF);
        issue(3'd0, 10'h0, 0, 0, 16'h0, 0);
        check("pc_wrap", pc, 10'h000);

        step();
        step();
        check("idle_hold", pc, 10'h000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("stray_ack_sp", sp, 10'h3FE);
        check("stray_ack_pc", pc, 10'h000);

        issue(3'd4, 10'h0, 0, 0, 16'hBEEF, 0);
        for (int i = 0; i < 4; i++) begin
            check("push_req", mem_req, 1'b1);
            check("push_we", mem_we, 1'b1);
            check("push_addr", mem_addr, 10'h3FE);
            check("push_wdata", mem_wdata, 16'hBEEF);
            check("push_busy", op_ready, 1'b0);
            if (i < 3) step();
        end
        ackStep(16'h0);
        check("push_done_req", mem_req, 1'b0);
        check("push_sp", sp, 10'h3FD);
        check("push_pc", pc, 10'h001);
        check("push_ready", op_ready, 1'b1);

        issue(3'd5, 10'h0, 0, 0, 16'h0, 0);
        check("pop_req", mem_req, 1'b1);
        check("pop_we", mem_we, 1'b0);
        check("pop_addr", mem_addr, 10'h3FE);
        ackStep(16'hBEEF);
        check("pop_valid", pop_valid, 1'b1);
        check("pop_data", pop_data, 16'hBEEF);
        check("pop_sp", sp, 10'h3FE);
        check("pop_pc", pc, 10'h002);
        step();
        check("pop_valid_drop", pop_valid, 1'b0);

        issue(3'd1, 10'h010, 0, 0, 16'h0, 0);
        check("jmp", pc, 10'h010);
        issue(3'd6, 10'h200, 0, 0, 16'h0, 0);
        check("call_we", mem_we, 1'b1);
        check("call_addr", mem_addr, 10'h3FE);
        check("call_wdata", mem_wdata, 16'h0011);
        ackStep(16'h0);
        check("call_pc", pc, 10'h200);
        check("call_sp", sp, 10'h3FD);
        issue(3'd7, 10'h0, 0, 0, 16'h0, 0);
        check("ret_we", mem_we, 1'b0);
        check("ret_addr", mem_addr, 10'h3FE);
        ackStep(16'h0011);
        check("ret_pc", pc, 10'h011);
        check("ret_sp", sp, 10'h3FE);

        issue(3'd4, 10'h0, 0, 0, 16'h1234, 0);
        step();
        check("mid_req", mem_req, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_req", mem_req, 1'b0);
        check("midrst_pc", pc, 10'h000);
        check("midrst_sp", sp, 10'h3FE);
        check("midrst_ready", op_ready, 1'b1);
        check("midrst_wdata", mem_wdata, 16'h0000);

        issue(3'd5, 10'h0, 0, 0, 16'h0, 0);
        check("uf_fault", fault, 2'b01);
        check("uf_req", mem_req, 1'b0);
        check("uf_ready", op_ready, 1'b0);
        issue(3'd0, 10'h0, 0, 0, 16'h0, 0);
        check("uf_hold_pc", pc, 10'h000);
        check("uf_hold_fault", fault, 2'b01);

        doReset();
        writes = 0;
        for (int i = 0; i < 64; i++) begin
            issue(3'd4, 10'h0, 0, 0, 16'(i), 0);
            if (mem_req && mem_we) writes++;
            ackStep(16'h0);
        end
        check("of_writes", writes, 64);
        check("of_sp_full", sp, 10'h3BE);
        issue(3'd4, 10'h0, 0, 0, 16'hDEAD, 0);
        check("of_req", mem_req, 1'b0);
        check("of_fault", fault, 2'b10);
        check("of_sp", sp, 10'h3BE);
        check("of_pc", pc, 10'h040);
        check("of_ready", op_ready, 1'b0);
        ackStep(16'h0);
        check("of_ack_ignored", sp, 10'h3BE);

        doReset();
        issue(3'd0, 10'h0, 0, 0, 16'h0, 0);
        check("pre_halt_pc", pc, 10'h001);
        issue(3'd1, 10'h300, 0, 0, 16'h0, 1);
        check("halt_pc", pc, 10'h001);
        check("halt_flag", halted, 1'b1);
        check("halt_ready", op_ready, 1'b0);
        issue(3'd0, 10'h0, 0, 0, 16'h0, 0);
        issue(3'd4, 10'h0, 0, 0, 16'h5555, 0);
        check("halt_ignore_pc", pc, 10'h001);
        check("halt_ignore_req", mem_req, 1'b0);
        check("halt_ignore_sp", sp, 10'h3FE);
        doReset();
        check("halt_exit", halted, 1'b0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
